// File: rtl/watermark_extractor.sv
// Recovers framed message bytes hidden in one bit of each pixel: hunts for a
// sync byte on a sliding bit window, then delivers PAYLOAD_LEN bytes MSB first.
module watermark_extractor #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         PAYLOAD_LEN = 16,
    parameter int         BIT_POS     = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_enable,
    input  logic [7:0] pixel,
    input  logic       pixel_valid,
    output logic [7:0] message_out,
    output logic       message_valid,
    output logic       locked,
    output logic       frame_done
);

    typedef enum logic {ST_HUNT, ST_LOCKED} state_t;

    localparam logic [7:0] LAST_BYTE = 8'(PAYLOAD_LEN - 1);

    state_t     state, state_d;
    logic [7:0] shift_reg, shift_d;
    logic [3:0] fill_cnt, fill_d;
    logic [2:0] bit_cnt, bit_d;
    logic [7:0] byte_cnt, byte_d;
    logic [7:0] msg_d;
    logic       mv_d, fd_d;

    logic       accept;
    logic [7:0] shift_nx;
    logic [3:0] fill_inc;

    assign accept   = clk_enable & pixel_valid;
    assign shift_nx = {shift_reg[6:0], pixel[BIT_POS]};
    assign fill_inc = (fill_cnt == 4'd8) ? 4'd8 : fill_cnt + 4'd1;
    assign locked   = (state == ST_LOCKED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_HUNT;
            shift_reg     <= 8'h00;
            fill_cnt      <= 4'd0;
            bit_cnt       <= 3'd0;
            byte_cnt      <= 8'd0;
            message_out   <= 8'h00;
            message_valid <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state         <= state_d;
            shift_reg     <= shift_d;
            fill_cnt      <= fill_d;
            bit_cnt       <= bit_d;
            byte_cnt      <= byte_d;
            message_out   <= msg_d;
            message_valid <= mv_d;
            frame_done    <= fd_d;
        end
    end

    always_comb begin
        state_d = state;
        shift_d = shift_reg;
        fill_d  = fill_cnt;
        bit_d   = bit_cnt;
        byte_d  = byte_cnt;
        msg_d   = message_out;
        mv_d    = 1'b0;
        fd_d    = 1'b0;
        if (accept) begin
            shift_d = shift_nx;
            case (state)
                ST_HUNT: begin
                    fill_d = fill_inc;
                    // Window only counts once 8 real bits have been seen since the last clear.
                    if (shift_nx == SYNC_BYTE && fill_inc == 4'd8) begin
                        state_d = ST_LOCKED;
                        bit_d   = 3'd0;
                        byte_d  = 8'd0;
                    end
                end
                ST_LOCKED: begin
                    if (bit_cnt == 3'd7) begin
                        msg_d  = shift_nx;
                        mv_d   = 1'b1;
                        bit_d  = 3'd0;
                        byte_d = byte_cnt + 8'd1;
                        if (byte_cnt == LAST_BYTE) begin
                            fd_d    = 1'b1;
                            state_d = ST_HUNT;
                            fill_d  = 4'd0;
                            shift_d = 8'h00;
                        end
                    end else begin
                        bit_d = bit_cnt + 3'd1;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

endmodule
